// File: rtl/pipe_alu_if.sv
// Operand/result bundle for pipe_alu: an input handshake (in_valid/in_ready)
// and an output handshake (out_valid/out_ready) carrying result and flags.
interface pipe_alu_if #(
    parameter int WIDTH = 32
) ();
    // Both handshakes: a beat transfers on a rising edge where valid && ready;
    // the sender holds its payload stable while valid is high and ready is low.
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero_f;
    logic             neg_f;
    logic             carry_f;
    logic             ovf_f;

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero_f, neg_f, carry_f, ovf_f
    );

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero_f, neg_f, carry_f, ovf_f
    );
endinterface

// File: rtl/pipe_alu.sv
// Single-cycle ALU with an iterative shift-add multiplier and a one-entry
// registered output stage; FSM state is exposed on dbg_state.
module pipe_alu #(
    parameter int WIDTH  = 32,
    parameter int SHW    = $clog2(WIDTH),
    parameter int MUL_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    pipe_alu_if.slave   bus,
    output logic        dbg_state
);
    typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_e;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]     mca_q, mca_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d, neg_q, neg_d;
    logic                 carry_q, carry_d, ovf_q, ovf_d;
    logic                 out_valid_q, out_valid_d;

    logic                 accept;
    logic                 mul_op;
    logic [WIDTH:0]       sum_ext, diff_ext, mul_step;
    logic [2*WIDTH-1:0]   prod_next;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c, alu_o;

    assign bus.in_ready  = rst_n && (state_q == IDLE) && (!out_valid_q || bus.out_ready) && !flush;
    assign accept        = bus.in_valid && bus.in_ready;
    assign mul_op        = (bus.op == OP_MUL) && (MUL_EN != 0);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero_f    = zero_q;
    assign bus.neg_f     = neg_q;
    assign bus.carry_f   = carry_q;
    assign bus.ovf_f     = ovf_q;
    assign dbg_state     = state_q;

    always_comb begin
        sum_ext  = {1'b0, bus.a} + {1'b0, bus.b};
        diff_ext = {1'b0, bus.a} - {1'b0, bus.b};
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_o    = 1'b0;
        case (bus.op)
            OP_AND: alu_res = bus.a & bus.b;
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_o   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];  // borrow out == (a < b) unsigned
                alu_o   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_OR:  alu_res = bus.a | bus.b;
            OP_XOR: alu_res = bus.a ^ bus.b;
            OP_SLL: alu_res = bus.a << bus.b[SHW-1:0];
            OP_SRL: alu_res = bus.a >> bus.b[SHW-1:0];
            default: alu_res = '0;  // MUL with the multiplier removed
        endcase
    end

    // Right-shifting product register: upper half accumulates the multiplicand,
    // lower half starts as the multiplier and is consumed LSB first.
    always_comb begin
        mul_step  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mca_q} : {(WIDTH+1){1'b0}});
        prod_next = {mul_step, prod_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mca_d       = mca_q;
        prod_d      = prod_q;
        result_d    = result_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (mul_op) begin
                        state_d = MUL_BUSY;
                        cnt_d   = '0;
                        mca_d   = bus.a;
                        prod_d  = {{WIDTH{1'b0}}, bus.b};
                    end else begin
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        neg_d       = alu_res[WIDTH-1];
                        carry_d     = alu_c;
                        ovf_d       = alu_o;
                        out_valid_d = 1'b1;
                    end
                end
            end
            MUL_BUSY: begin
                prod_d = prod_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    result_d    = prod_next[WIDTH-1:0];
                    zero_d      = (prod_next[WIDTH-1:0] == '0);
                    neg_d       = prod_next[WIDTH-1];
                    carry_d     = 1'b0;
                    ovf_d       = |prod_next[2*WIDTH-1:WIDTH];
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d     = IDLE;
            cnt_d       = '0;
            result_d    = result_q;
            zero_d      = zero_q;
            neg_d       = neg_q;
            carry_d     = carry_q;
            ovf_d       = ovf_q;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mca_q       <= '0;
            prod_q      <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mca_q       <= mca_d;
            prod_q      <= prod_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_pipe_alu.sv
// Directed bench for pipe_alu at WIDTH=32: each task drives one scenario and
// checks outputs against hand-computed values 1 ns after the rising edge.
module tb_pipe_alu;
  localparam int W = 32;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic clk;
  logic rst_n;
  logic flush;
  logic dbg_state;
  int   total;
  int   bad;

  pipe_alu_if #(.WIDTH(W)) bus ();

  pipe_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    bus.in_valid = v;
    bus.op       = o;
    bus.a        = x;
    bus.b        = y;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; bus.out_ready = 1'b1;
    drive(1'b1, OP_ADD, 32'd1, 32'd1);
    #3;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", bus.result); end
    total++; if ({bus.zero_f, bus.neg_f, bus.carry_f, bus.ovf_f} !== 4'b0000) begin bad++;
      $display("FAIL reset_flags got=%b exp=0000", {bus.zero_f, bus.neg_f, bus.carry_f, bus.ovf_f}); end
    total++; if (dbg_state !== 1'b0) begin bad++; $display("FAIL reset_state got=%b exp=0", dbg_state); end
    tick();
    tick();
    rst_n = 1'b1;
    drive(1'b1, OP_ADD, 32'd2, 32'd3);
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", bus.in_ready); end
    tick();
    drive(1'b0, OP_AND, 32'd0, 32'd0);
    total++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd5) begin bad++;
      $display("FAIL first_transfer got v=%b r=%h exp v=1 r=5", bus.out_valid, bus.result); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL valid_drop got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_add();
    drive(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'h1);
    tick();
    drive(1'b0, OP_AND, 32'd0, 32'd0);
    total++; if (bus.out_valid !== 1'b1 || bus.result !== 32'h8000_0000) begin bad++;
      $display("FAIL add_ovf_result got v=%b r=%h exp v=1 r=80000000", bus.out_valid, bus.result); end
    total++; if ({bus.zero_f, bus.neg_f, bus.carry_f, bus.ovf_f} !== 4'b0101) begin bad++;
      $display("FAIL add_ovf_flags got=%b exp=0101", {bus.zero_f, bus.neg_f, bus.carry_f, bus.ovf_f}); end
    drive(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h1);
    tick();
    drive(1'b0, OP_AND, 32'd0, 32'd0);
    total++; if (bus.result !== 32'h0 || {bus.zero_f, bus.neg_f, bus.carry_f, bus.ovf_f} !== 4'b1010) begin bad++;
      $display("FAIL add_carry got r=%h f=%b exp r=0 f=1010", bus.result, {bus.zero_f, bus.neg_f, bus.carry_f, bus.ovf_f}); end
    tick();
  endtask

  task automatic test_sub();
    drive(1'b1, OP_SUB, 32'd5, 32'd5);
    tick();
    total++; if (bus.result !== 32'h0 || {bus.zero_f, bus.neg_f, bus.carry_f, bus.ovf_f} !== 4'b1000) begin bad++;
      $display("FAIL sub_zero got r=%h f=%b exp r=0 f=1000", bus.result, {bus.zero_f, bus.neg_f, bus.carry_f, bus.ovf_f}); end
    drive(1'b1, OP_SUB, 32'd3, 32'd5);
    tick();
    drive(1'b0, OP_AND, 32'd0, 32'd0);
    total++; if (bus.out_valid !== 1'b1 || bus.result !== 32'hFFFF_FFFE) begin bad++;
      $display("FAIL sub_borrow_result got v=%b r=%h exp v=1 r=fffffffe", bus.out_valid, bus.result); end
    total++; if ({bus.zero_f, bus.neg_f, bus.carry_f, bus.ovf_f} !== 4'b0110) begin bad++;
      $display("FAIL sub_borrow_flags got=%b exp=0110", {bus.zero_f, bus.neg_f, bus.carry_f, bus.ovf_f}); end
    drive(1'b1, OP_SUB, 32'h8000_0000, 32'd1);
    tick();
    drive(1'b0, OP_AND, 32'd0, 32'd0);
    total++; if (bus.result !== 32'h7FFF_FFFF || {bus.zero_f, bus.neg_f, bus.carry_f, bus.ovf_f} !== 4'b0001) begin bad++;
      $display("FAIL sub_ovf got r=%h f=%b exp r=7fffffff f=0001", bus.result, {bus.zero_f, bus.neg_f, bus.carry_f, bus.ovf_f}); end
    tick();
  endtask

  task automatic test_logic_shift();
    logic [2:0]   ops [6] = '{OP_SLL, OP_SRL, OP_SLL, OP_AND, OP_OR, OP_XOR};
    logic [W-1:0] av  [6] = '{32'h1, 32'h8000_0000, 32'hDEAD_BEEF, 32'hF0F0_F0F0, 32'h0F00_0000, 32'hFFFF_0000};
    logic [W-1:0] bv  [6] = '{32'h25, 32'd31, 32'h20, 32'h0FF0_0FF0, 32'h8000_0001, 32'hFFFF_0000};
    logic [W-1:0] ev  [6] = '{32'h20, 32'h1, 32'hDEAD_BEEF, 32'h00F0_00F0, 32'h8F00_0001, 32'h0};
    logic [3:0]   fv  [6] = '{4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b1000};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, ops[i], av[i], bv[i]);
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.result !== ev[i] ||
                   {bus.zero_f, bus.neg_f, bus.carry_f, bus.ovf_f} !== fv[i]) begin bad++;
        $display("FAIL logic_shift_%0d got v=%b r=%h f=%b exp v=1 r=%h f=%b", i, bus.out_valid, bus.result,
                 {bus.zero_f, bus.neg_f, bus.carry_f, bus.ovf_f}, ev[i], fv[i]); end
    end
    drive(1'b0, OP_AND, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_mul();
    logic [W-1:0] av [3] = '{32'h0001_0000, 32'h0000_1234, 32'hFFFF_FFFF};
    logic [W-1:0] bv [3] = '{32'h0001_0000, 32'h0000_5678, 32'h0000_0003};
    logic [W-1:0] ev [3] = '{32'h0,         32'h0626_0060, 32'hFFFF_FFFD};
    logic [3:0]   fv [3] = '{4'b1001,       4'b0000,       4'b0101};
    int early;
    for (int t = 0; t < 3; t++) begin
      drive(1'b1, OP_MUL, av[t], bv[t]);
      tick();
      drive(1'b0, OP_AND, 32'd0, 32'd0);
      early = 0;
      for (int n = 1; n < W; n++) begin
        #1;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || dbg_state !== 1'b1) early++;
        tick();
      end
      total++; if (early != 0) begin bad++; $display("FAIL mul_busy_%0d got %0d bad busy cycles exp 0", t, early); end
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.result !== ev[t] ||
                   {bus.zero_f, bus.neg_f, bus.carry_f, bus.ovf_f} !== fv[t]) begin bad++;
        $display("FAIL mul_result_%0d got v=%b r=%h f=%b exp v=1 r=%h f=%b", t, bus.out_valid, bus.result,
                 {bus.zero_f, bus.neg_f, bus.carry_f, bus.ovf_f}, ev[t], fv[t]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int hold_bad;
    bus.out_ready = 1'b0;
    drive(1'b1, OP_ADD, 32'd10, 32'd20);
    tick();
    drive(1'b1, OP_ADD, 32'd1, 32'd1);
    hold_bad = 0;
    for (int n = 0; n < 5; n++) begin
      #1;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.result !== 32'd30) hold_bad++;
      tick();
    end
    total++; if (hold_bad != 0) begin bad++; $display("FAIL backpressure_hold got %0d bad cycles exp 0", hold_bad); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, OP_ADD, 32'(i * 100), 32'd7);
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.result !== 32'(i * 100 + 7)) begin bad++;
        $display("FAIL stream_%0d got v=%b r=%h exp v=1 r=%h", i, bus.out_valid, bus.result, 32'(i * 100 + 7)); end
    end
    drive(1'b0, OP_AND, 32'd0, 32'd0);
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_flush();
    int stale;
    bus.out_ready = 1'b0;
    drive(1'b1, OP_ADD, 32'd4, 32'd4);
    tick();
    drive(1'b0, OP_AND, 32'd0, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_output got=%b exp=0", bus.out_valid); end
    bus.out_ready = 1'b1;
    drive(1'b1, OP_MUL, 32'd7, 32'd9);
    tick();
    drive(1'b0, OP_AND, 32'd0, 32'd0);
    for (int n = 0; n < 10; n++) tick();
    flush = 1'b1;
    drive(1'b1, OP_OR, 32'h1234, 32'h1);
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", bus.in_ready); end
    tick();
    flush = 1'b0;
    drive(1'b0, OP_AND, 32'd0, 32'd0);
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || dbg_state !== 1'b0) begin bad++;
      $display("FAIL flush_mul got v=%b rdy=%b st=%b exp 0 1 0", bus.out_valid, bus.in_ready, dbg_state); end
    stale = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (bus.out_valid !== 1'b0) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL flush_stale got %0d valid cycles exp 0", stale); end
    drive(1'b1, OP_AND, 32'hF0, 32'h3C);
    tick();
    drive(1'b0, OP_AND, 32'd0, 32'd0);
    total++; if (bus.out_valid !== 1'b1 || bus.result !== 32'h30) begin bad++;
      $display("FAIL flush_then_and got v=%b r=%h exp v=1 r=30", bus.out_valid, bus.result); end
    tick();
  endtask

  task automatic test_reset_mul();
    drive(1'b1, OP_MUL, 32'hFFFF, 32'hFFFF);
    tick();
    drive(1'b0, OP_AND, 32'd0, 32'd0);
    for (int n = 0; n < 10; n++) tick();
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || dbg_state !== 1'b0 || bus.result !== 32'h0) begin bad++;
      $display("FAIL reset_mul got v=%b rdy=%b st=%b r=%h exp 0 0 0 0", bus.out_valid, bus.in_ready, dbg_state, bus.result); end
    tick();
    rst_n = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_mul_ready got=%b exp=1", bus.in_ready); end
    drive(1'b1, OP_AND, 32'hF0, 32'h3C);
    tick();
    drive(1'b0, OP_AND, 32'd0, 32'd0);
    total++; if (bus.out_valid !== 1'b1 || bus.result !== 32'h30) begin bad++;
      $display("FAIL reset_then_and got v=%b r=%h exp v=1 r=30", bus.out_valid, bus.result); end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add();
    test_sub();
    test_logic_shift();
    test_mul();
    test_back_to_back();
    test_flush();
    test_reset_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_alu.md
PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values 8..64, power of two.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have parameter MUL_EN, default 1; 0 removes the multiplier, and opcode MUL then yields result 0.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous abort of in-flight work and output.
REQ-007 in_valid  input  1  operand/opcode bundle valid.
REQ-008 in_ready  output  1  block can accept a bundle this cycle.
REQ-009 op  input  3  000 AND, 001 ADD, 010 SUB, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 MUL.
REQ-010 a, b  input  WIDTH  operands.
REQ-011 out_valid  output  1  result and flags valid.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 result  output  WIDTH  registered result.
REQ-014 zero_f, neg_f, carry_f, ovf_f  output  1 each  registered flags.

Function
REQ-015 A transfer SHALL occur when in_valid && in_ready at a rising edge; a, b, op are sampled only then.
REQ-016 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready) && !flush.
REQ-017 The FSM SHALL have states IDLE and MUL_BUSY; a MUL transfer moves IDLE->MUL_BUSY, and the last iteration returns to IDLE.
REQ-018 Non-MUL ops SHALL register result and flags at the accepting edge, so out_valid is high in the next cycle; sustained throughput is 1 per cycle.
REQ-019 MUL SHALL be an iterative shift-add over b, LSB first, one bit per cycle.
REQ-020 For MUL, result = low WIDTH bits of unsigned a*b, and out_valid rises at the WIDTH-th edge after the accepting edge.
REQ-021 ADD/SUB SHALL be modulo 2^WIDTH.
REQ-022 carry_f SHALL be the carry-out for ADD and the borrow (a<b unsigned) for SUB.
REQ-023 ovf_f SHALL be signed two's-complement overflow for ADD/SUB.
REQ-024 For MUL, carry_f = 0 and ovf_f = 1 iff the high WIDTH bits of the product are nonzero.
REQ-025 For logic and shift ops, carry_f = ovf_f = 0.
REQ-026 SLL/SRL SHALL be logical shifts by b[SHW-1:0], ignoring the upper bits of b; a shift of 0 returns a.
REQ-027 zero_f SHALL equal (result==0), and neg_f SHALL equal result[WIDTH-1], for every op.
REQ-028 While out_valid && !out_ready, result and flags SHALL hold stable and no new transfer is accepted.
REQ-029 If out_valid && out_ready coincides with a new transfer, the new non-MUL result SHALL replace the old one with out_valid staying 1.
REQ-030 If out_valid && out_ready occurs with no new completion, out_valid SHALL drop to 0 next cycle.
REQ-031 A MUL completion SHALL NOT be blocked, because MUL was accepted only with the output free and in_ready stays 0 while busy.
REQ-032 flush SHALL, at the next edge, clear out_valid, abort MUL_BUSY to IDLE, and discard any bundle presented that cycle.
REQ-033 flush SHALL have priority over all other events.

Reset
REQ-034 rst_n low SHALL immediately force state=IDLE, out_valid=0, result=0, all flags=0, and iteration counter=0.
REQ-035 While rst_n is low, in_ready SHALL be 0.
REQ-036 Reset mid-MUL SHALL discard the operation.
REQ-037 After rst_n deasserts, the first transfer SHALL be possible at the first rising edge.

Verification
REQ-038 WIDTH=32, ADD a=0x7FFFFFFF b=1 -> next cycle result=0x80000000, neg_f=1, ovf_f=1, carry_f=0, zero_f=0.
REQ-039 SUB a=5 b=5 -> result=0, zero_f=1, carry_f=0; then SUB a=3 b=5 -> result=0xFFFFFFFE, carry_f=1, neg_f=1.
REQ-040 MUL a=0x10000 b=0x10000 -> out_valid exactly 32 edges after accept, result=0, ovf_f=1, zero_f=1, in_ready=0 throughout.
REQ-041 SLL a=1 b=0x25 -> result=0x20; SRL a=0x80000000 b=31 -> result=1.
REQ-042 Hold out_ready=0 with out_valid=1 for 5 cycles -> in_ready=0, result stable; then stream 4 ADDs with out_ready=1 -> 4 results on 4 consecutive cycles.
REQ-043 Assert rst_n low (or flush) 10 cycles into a MUL -> out_valid=0, in_ready=1 after release, and a following AND 0xF0&0x3C yields 0x30.
